// File: rtl/fsm_seq_gen.sv
// Multi-mode sequence generator: steps q through up, down, Gray, Johnson or
// one-hot ring sequences under en, with load, clear and one-shot termination.
module fsm_seq_gen #(
    parameter int WIDTH     = 3,
    parameter int MAX_COUNT = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    input  logic [2:0]       mode,
    input  logic             oneshot,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] MODE_UP    = 3'd0;
    localparam logic [2:0] MODE_DOWN  = 3'd1;
    localparam logic [2:0] MODE_GRAY  = 3'd2;
    localparam logic [2:0] MODE_JOHN  = 3'd3;
    localparam logic [2:0] MODE_RING  = 3'd4;

    localparam logic [WIDTH-1:0] ZERO_V      = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_V       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TOP_V       = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_V       = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] GRAY_TERM_V = MAX_V ^ {1'b0, MAX_V[WIDTH-1:1]};

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] step_val_s;
    logic [WIDTH-1:0] term_val_s;
    logic             term_ok_s;
    logic             tc_s;
    logic [WIDTH-1:0] seed_s;

    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
        return b ^ {1'b0, b[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Values at or beyond MAX_COUNT wrap to zero so loaded out-of-range values recover.
    function automatic logic [WIDTH-1:0] up_step(input logic [WIDTH-1:0] b);
        return (b >= MAX_V) ? ZERO_V : (b + ONE_V);
    endfunction

    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        return (v != ZERO_V) && ((v & (v - ONE_V)) == ZERO_V);
    endfunction

    // Next value of q for the currently selected mode.
    always_comb begin
        step_val_s = q_r;
        case (mode)
            MODE_UP:   step_val_s = up_step(q_r);
            MODE_DOWN: begin
                if ((q_r == ZERO_V) || (q_r > MAX_V)) begin
                    step_val_s = MAX_V;
                end else begin
                    step_val_s = q_r - ONE_V;
                end
            end
            MODE_GRAY: step_val_s = bin_to_gray(up_step(gray_to_bin(q_r)));
            MODE_JOHN: step_val_s = {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
            MODE_RING: begin
                if (is_onehot(q_r)) begin
                    step_val_s = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                end else begin
                    step_val_s = ONE_V;
                end
            end
            default:   step_val_s = q_r;
        endcase
    end

    // Terminal value per mode; hold modes never report terminal.
    always_comb begin
        term_val_s = ZERO_V;
        term_ok_s  = 1'b0;
        case (mode)
            MODE_UP:   begin term_val_s = MAX_V;       term_ok_s = 1'b1; end
            MODE_DOWN: begin term_val_s = ZERO_V;      term_ok_s = 1'b1; end
            MODE_GRAY: begin term_val_s = GRAY_TERM_V; term_ok_s = 1'b1; end
            MODE_JOHN: begin term_val_s = TOP_V;       term_ok_s = 1'b1; end
            MODE_RING: begin term_val_s = TOP_V;       term_ok_s = 1'b1; end
            default:   begin term_val_s = ZERO_V;      term_ok_s = 1'b0; end
        endcase
        tc_s = term_ok_s && (q_r == term_val_s);
    end

    // Seed value restored by clear: ring mode needs a single hot bit.
    always_comb begin
        seed_s = ZERO_V;
        if (mode == MODE_RING) begin
            seed_s = ONE_V;
        end else begin
            seed_s = ZERO_V;
        end
    end

    // Control FSM: clear beats load beats step; DONE only exits via clear or load.
    always_comb begin
        state_next_s = state_r;
        q_next_s     = q_r;
        if (clear) begin
            q_next_s     = seed_s;
            state_next_s = ST_IDLE;
        end else if (load) begin
            q_next_s     = load_val;
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_RUN: begin
                    if (en && oneshot && tc_s) begin
                        q_next_s     = q_r;
                        state_next_s = ST_DONE;
                    end else if (en) begin
                        q_next_s     = step_val_s;
                        state_next_s = ST_RUN;
                    end else begin
                        q_next_s     = q_r;
                        state_next_s = state_r;
                    end
                end
                ST_DONE: begin
                    q_next_s     = q_r;
                    state_next_s = ST_DONE;
                end
                default: begin
                    q_next_s     = q_r;
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, sequence value and status flags all register on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            q_r     <= ZERO_V;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            q_r     <= q_next_s;
            busy_r  <= (state_next_s == ST_RUN);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    assign q    = q_r;
    assign tc   = tc_s;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Scoreboard bench for fsm_seq_gen: three configurations share one set of
// control inputs; each scenario task checks the instance it targets.
module tb_fsm_seq_gen;

    typedef struct packed {
        logic [3:0] q;
        logic       tc;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       load;
    logic       clear;
    logic       oneshot;
    logic [2:0] mode;
    logic [3:0] load_val;

    logic [2:0] qa, qb;
    logic [3:0] qc;
    logic       tca, tcb, tcc;
    logic       busya, busyb, busyc;
    logic       donea, doneb, donec;

    exp_t obs_a, obs_b, obs_c;
    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fsm_seq_gen #(.WIDTH(3), .MAX_COUNT(7)) u_a (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val[2:0]),
        .clear(clear), .mode(mode), .oneshot(oneshot),
        .q(qa), .tc(tca), .busy(busya), .done(donea)
    );

    fsm_seq_gen #(.WIDTH(3), .MAX_COUNT(5)) u_b (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val[2:0]),
        .clear(clear), .mode(mode), .oneshot(oneshot),
        .q(qb), .tc(tcb), .busy(busyb), .done(doneb)
    );

    fsm_seq_gen #(.WIDTH(4), .MAX_COUNT(15)) u_c (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
        .clear(clear), .mode(mode), .oneshot(oneshot),
        .q(qc), .tc(tcc), .busy(busyc), .done(donec)
    );

    assign obs_a = {1'b0, qa, tca, busya, donea};
    assign obs_b = {1'b0, qb, tcb, busyb, doneb};
    assign obs_c = {qc, tcc, busyc, donec};

    function automatic exp_t mk(input int qv, input logic t, input logic b, input logic d);
        exp_t e;
        e.q    = 4'(qv);
        e.tc   = t;
        e.busy = b;
        e.done = d;
        return e;
    endfunction

    task automatic drive(input logic l, input logic c, input logic e, input logic [2:0] m,
                         input logic o, input logic [3:0] lv);
        load = l; clear = c; en = e; mode = m; oneshot = o; load_val = lv;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0);
        #2;
        sb_q.push_back(mk(0, 1'b0, 1'b0, 1'b0));
        e = sb_q.pop_front();
        n_tests++;
        if (obs_a !== e) begin
            n_fail++;
            $display("FAIL reset_a got=%b exp=%b", obs_a, e);
        end
        mode = 3'd1;
        #1;
        sb_q.push_back(mk(0, 1'b1, 1'b0, 1'b0));
        e = sb_q.pop_front();
        n_tests++;
        if (obs_b !== e) begin
            n_fail++;
            $display("FAIL reset_tc_down got=%b exp=%b", obs_b, e);
        end
        mode = 3'd0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_up_wrap();
        exp_t e;
        drive(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd0);
        for (int k = 1; k <= 10; k++) begin
            sb_q.push_back(mk(k % 8, (k % 8) == 7, 1'b1, 1'b0));
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_tests++;
            if (obs_a !== e) begin
                n_fail++;
                $display("FAIL up_wrap[%0d] got=%b exp=%b", k, obs_a, e);
            end
        end
    endtask

    task automatic test_down_oneshot();
        exp_t e;
        exp_t tbl[9];
        tbl = '{mk(3, 1'b0, 1'b0, 1'b0), mk(2, 1'b0, 1'b1, 1'b0), mk(1, 1'b0, 1'b1, 1'b0),
                mk(0, 1'b1, 1'b1, 1'b0), mk(0, 1'b1, 1'b0, 1'b1), mk(0, 1'b1, 1'b0, 1'b1),
                mk(0, 1'b1, 1'b0, 1'b1), mk(0, 1'b1, 1'b0, 1'b1), mk(0, 1'b1, 1'b0, 1'b0)};
        for (int k = 0; k < 9; k++) begin
            if (k == 0)      drive(1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 4'd3);
            else if (k == 8) drive(1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 4'd0);
            else             drive(1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 4'd0);
            sb_q.push_back(tbl[k]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_tests++;
            if (obs_b !== e) begin
                n_fail++;
                $display("FAIL down_oneshot[%0d] got=%b exp=%b", k, obs_b, e);
            end
        end
    endtask

    task automatic test_gray();
        exp_t e;
        logic [3:0] prev;
        logic [3:0] gseq[16];
        gseq = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12,
                 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8, 4'd0};
        drive(1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 4'd0);
        sb_q.push_back(mk(0, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        e = sb_q.pop_front();
        n_tests++;
        if (obs_c !== e) begin
            n_fail++;
            $display("FAIL gray_clear got=%b exp=%b", obs_c, e);
        end
        prev = qc;
        drive(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 4'd0);
        for (int k = 0; k < 16; k++) begin
            sb_q.push_back(mk(int'(gseq[k]), gseq[k] == 4'd8, 1'b1, 1'b0));
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_tests++;
            if (obs_c !== e) begin
                n_fail++;
                $display("FAIL gray[%0d] got=%b exp=%b", k, obs_c, e);
            end
            n_tests++;
            if ($countones(prev ^ qc) !== 1) begin
                n_fail++;
                $display("FAIL gray_hamming[%0d] got=%0d exp=1", k, $countones(prev ^ qc));
            end
            prev = qc;
        end
    endtask

    task automatic test_johnson_ring();
        exp_t e;
        int jseq[6];
        int rseq[4];
        jseq = '{1, 3, 7, 6, 4, 0};
        rseq = '{1, 2, 4, 1};
        drive(1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 4'd0);
        sb_q.push_back(mk(0, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        e = sb_q.pop_front();
        n_tests++;
        if (obs_a !== e) begin
            n_fail++;
            $display("FAIL johnson_clear got=%b exp=%b", obs_a, e);
        end
        drive(1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 4'd0);
        for (int k = 0; k < 12; k++) begin
            sb_q.push_back(mk(jseq[k % 6], jseq[k % 6] == 4, 1'b1, 1'b0));
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_tests++;
            if (obs_a !== e) begin
                n_fail++;
                $display("FAIL johnson[%0d] got=%b exp=%b", k, obs_a, e);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 4'd5);
        sb_q.push_back(mk(5, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        e = sb_q.pop_front();
        n_tests++;
        if (obs_a !== e) begin
            n_fail++;
            $display("FAIL ring_load got=%b exp=%b", obs_a, e);
        end
        drive(1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 4'd0);
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back(mk(rseq[k], rseq[k] == 4, 1'b1, 1'b0));
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_tests++;
            if (obs_a !== e) begin
                n_fail++;
                $display("FAIL ring[%0d] got=%b exp=%b", k, obs_a, e);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        exp_t tbl[5];
        tbl = '{mk(5, 1'b0, 1'b0, 1'b0), mk(6, 1'b0, 1'b1, 1'b0), mk(0, 1'b0, 1'b0, 1'b0),
                mk(0, 1'b1, 1'b0, 1'b0), mk(1, 1'b0, 1'b1, 1'b0)};
        for (int k = 0; k < 5; k++) begin
            sb_q.push_back(tbl[k]);
            case (k)
                0: begin drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'd5); @(posedge clk); #1; end
                1: begin drive(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd0); @(posedge clk); #1; end
                2: begin @(negedge clk); reset = 1'b0; #1; end
                3: begin mode = 3'd1; #1; end
                default: begin
                    mode = 3'd0;
                    @(negedge clk);
                    reset = 1'b1;
                    @(posedge clk); #1;
                end
            endcase
            e = sb_q.pop_front();
            n_tests++;
            if (obs_a !== e) begin
                n_fail++;
                $display("FAIL async_reset[%0d] got=%b exp=%b", k, obs_a, e);
            end
        end
    endtask

    task automatic test_priority();
        exp_t e;
        exp_t tbl[3];
        tbl = '{mk(0, 1'b0, 1'b0, 1'b0), mk(5, 1'b0, 1'b0, 1'b0), mk(1, 1'b0, 1'b0, 1'b0)};
        for (int k = 0; k < 3; k++) begin
            if (k == 0)      drive(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 4'd5);
            else if (k == 1) drive(1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 4'd5);
            else             drive(1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 4'd0);
            sb_q.push_back(tbl[k]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_tests++;
            if (obs_a !== e) begin
                n_fail++;
                $display("FAIL priority[%0d] got=%b exp=%b", k, obs_a, e);
            end
        end
    endtask

    task automatic test_oneshot_up_hold();
        exp_t e;
        exp_t tbl[6];
        tbl = '{mk(6, 1'b0, 1'b0, 1'b0), mk(7, 1'b1, 1'b1, 1'b0), mk(7, 1'b1, 1'b0, 1'b1),
                mk(2, 1'b0, 1'b0, 1'b0), mk(2, 1'b0, 1'b1, 1'b0), mk(2, 1'b0, 1'b1, 1'b0)};
        for (int k = 0; k < 6; k++) begin
            case (k)
                0:       drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 4'd6);
                1, 2:    drive(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 4'd0);
                3:       drive(1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 4'd2);
                default: drive(1'b0, 1'b0, 1'b1, 3'd5, 1'b1, 4'd0);
            endcase
            sb_q.push_back(tbl[k]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_tests++;
            if (obs_a !== e) begin
                n_fail++;
                $display("FAIL oneshot_hold[%0d] got=%b exp=%b", k, obs_a, e);
            end
        end
    endtask

    task automatic test_bounds();
        exp_t e;
        exp_t tbl[5];
        tbl = '{mk(4, 1'b0, 1'b0, 1'b0), mk(5, 1'b1, 1'b1, 1'b0), mk(0, 1'b0, 1'b1, 1'b0),
                mk(7, 1'b0, 1'b0, 1'b0), mk(5, 1'b0, 1'b1, 1'b0)};
        for (int k = 0; k < 5; k++) begin
            case (k)
                0:       drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'd4);
                1, 2:    drive(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd0);
                3:       drive(1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 4'd7);
                default: drive(1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 4'd0);
            endcase
            sb_q.push_back(tbl[k]);
            @(posedge clk); #1;
            e = sb_q.pop_front();
            n_tests++;
            if (obs_b !== e) begin
                n_fail++;
                $display("FAIL bounds[%0d] got=%b exp=%b", k, obs_b, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_oneshot();
        test_gray();
        test_johnson_ring();
        test_async_reset();
        test_priority();
        test_oneshot_up_hold();
        test_bounds();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_seq_gen.md
# fsm_seq_gen

Parametrised multi-mode sequence-generator FSM, the successor to the fixed 3-bit auto-counter FSM. It steps a WIDTH-bit registered output `q` through one of five sequences: binary up, binary down, Gray, Johnson, or one-hot ring. Each step is gated by `en`, and the block adds load, clear, one-shot termination and status flags. It sits under the FSM generator flow as the canonical sequential target that generated testbenches drive with `clk`/`reset` and monitor on `q`.

## Interface
- `WIDTH`, 3: width of `q`; must be ≥2.
- `MAX_COUNT`, 2**WIDTH-1: last binary index for modes 0–2; must satisfy 1 ≤ MAX_COUNT ≤ 2**WIDTH-1.

- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset. Low = reset asserted.
- `en`  in  1  advance `q` one step on this edge.
- `load`  in  1  synchronous load of `load_val`.
- `load_val`  in  WIDTH  value written to `q` on load.
- `clear`  in  1  synchronous return to seed value and IDLE.
- `mode`  in  3  0 up, 1 down, 2 Gray, 3 Johnson, 4 ring, 5–7 hold.
- `oneshot`  in  1  1 = stop at terminal value; 0 = wrap.
- `q`  out  WIDTH  registered sequence output.
- `tc`  out  1  combinational: `q` equals the terminal value of the current mode.
- `busy`  out  1  registered: state == RUN.
- `done`  out  1  registered: state == DONE.

## Operation
- **Control states:** IDLE, RUN, DONE. Reset → IDLE.
- **Priority each edge:** clear > load > step.
  - clear: `q` ← seed (0; 1 in ring mode). State → IDLE.
  - load: `q` ← `load_val`. State → IDLE from any state.
- **Step (`en`=1, state IDLE or RUN):** `q` ← next(`q`, `mode`). State → RUN. `en`=0 in RUN: hold `q`, stay in RUN.
- **Next-value and terminal rules:**
  - Mode 0 (up): q+1. If q ≥ MAX_COUNT, next is 0. Terminal = MAX_COUNT.
  - Mode 1 (down): q−1. If q == 0 or q > MAX_COUNT, next is MAX_COUNT. Terminal = 0.
  - Mode 2 (Gray): convert q to binary b, step b as in mode 0, output gray(b) = b ^ (b>>1). Terminal = gray(MAX_COUNT). The wrap step need not be single-bit when MAX_COUNT+1 is not a power of two.
  - Mode 3 (Johnson): {q[WIDTH-2:0], ~q[WIDTH-1]}. Period 2·WIDTH from 0. Terminal = 1<<(WIDTH-1).
  - Mode 4 (ring): rotate left. If q is not one-hot, next is 1 (self-correcting). Terminal = 1<<(WIDTH-1).
  - Modes 5–7: `q` holds. `tc` = 0. State still → RUN on `en`.
- **Step from terminal:**
  - `oneshot`=0: wrap per the rules above. Stay in RUN.
  - `oneshot`=1: `q` holds the terminal value. State → DONE.
- **DONE:** ignores `en`. Leaves only via clear or load, both of which go to IDLE.
- **Mode changes:** `mode` and `oneshot` are sampled every edge with no latching. A change mid-run applies the new mode's next function to the current `q`.

## Timing
- **Async reset assertion (`reset` low):** immediately `q`=0, state IDLE, `busy`=0, `done`=0. `tc` follows `q`/`mode` combinationally, e.g. 1 in mode 1.
- **Reset release:** synchronised externally. The first rising edge with `reset` high is a normal cycle.
- **Latency:** `q`, `busy` and `done` update on the same rising edge that samples `en`/`load`/`clear`. One-cycle latency, no pipelining.
- **`tc`:** valid in the same cycle `q` reaches the terminal value. With `oneshot`=1, `done` rises on the next enabled edge.
- **Reset mid-RUN or in DONE:** aborts immediately. No pending step survives.
- **Simultaneous `load` and `en`:** `q` = `load_val`, no step, state IDLE.
- **Simultaneous `clear` and `load`:** clear wins.

## Test plan
- WIDTH=3, mode 0, `oneshot`=0, `en`=1, 10 edges after reset → `q` = 1..7, 0, 1, 2. `tc`=1 only while `q`=7. `busy`=1 from the first edge.
- WIDTH=3, MAX_COUNT=5, mode 1, `oneshot`=1, load 3 then `en`=1 → `q` = 2, 1, 0, then holds 0. `done`=1 on the edge after `q` reached 0. `en` pulses are then ignored. `clear` → `q`=0, IDLE, `done`=0.
- WIDTH=4, mode 2, 16 edges → `q` = 0001, 0011, 0010, 0110, …, 1000, 0000. Every step is single-bit (Hamming distance 1).
- WIDTH=3, mode 3 from reset → 001, 011, 111, 110, 100, 000, repeating with period 6. Then mode 4 with `load_val`=101 → next `q`=001, then 010, 100, 001.
- Assert `reset` low asynchronously between edges mid-RUN with `q`=6 → `q`=0 and `busy`=0 before the next edge. After release, the first `en` edge gives `q`=1.
- Same-edge `clear`+`load`+`en` with `load_val`=5 → `q`=0 (seed), IDLE. Next edge with `load`+`en` → `q`=5, IDLE, `busy`=0.
